mult_product_combiner: RTL
==========================

Name: mult_product_combiner

Overview:
- Back end of the 8-lane 8x8 vector multiplier array.
- Accepts the eight 16-bit lane partial products plus the SEW/pass tag that steered operand splitting.
- Shifts and sums them into final unsigned products: 8x16-bit (SEW=8), 2x32-bit (SEW=16), or 1x64-bit (SEW=32).
- SEW=32 needs two passes (count_0=0, then count_0=1); the first pass is held in an internal accumulator. Output uses a valid/ready register stage feeding vector writeback.

Parameters:
- LANES, 8, number of 8x8 partial products per pass (fixed; other values unsupported).
- PPW, 16, width of one partial product.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pp_valid  input  1  partial-product set valid
- pp_ready  output  1  combiner accepts set this cycle
- pp_in  input  128  lane k partial product at [16k+15:16k], k=0..7
- sew  input  2  00=8b, 01=16b, 10=32b, 11=reserved
- count_0  input  1  pass index for SEW=32 (0=first, 1=second); ignored otherwise
- res_valid  output  1  result valid
- res_ready  input  1  downstream accepts result
- res_data  output  128  combined product(s)
- res_sew  output  2  SEW tag of res_data
- err  output  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (async):
  - res_valid=0, res_data=0, res_sew=0, err=0.
  - FSM=IDLE, accumulator=0.
  - pp_ready=1 once reset deasserts.
- Handshake:
  - Accept = pp_valid & pp_ready.
  - pp_ready = !res_valid | res_ready, a single output register; no combinational path from pp_in to res_data.
  - Result holds stable while res_valid & !res_ready.
- SEW=00:
  - res_data lane k = pp_in lane k.
  - res_valid rises the cycle after accept (latency 1).
- SEW=01:
  - Element e=0,1 uses lanes 4e..4e+3 = a0b0, a0b1, a1b0, a1b1.
  - P_e = L0 + (L1<<8) + (L2<<8) + (L3<<16), 32-bit, no overflow possible.
  - res_data[32e+31:32e]=P_e; [127:64]=0; latency 1.
- SEW=10:
  - Lane k = 4*i' + j carries a(i'+2*count_0)*b(j), weight 8*(i'+2*count_0+j).
  - Each pass sums its eight weighted lanes into a 64-bit value.
- FSM for SEW=10:
  - IDLE, accept with sew=10 & count_0=0: accumulator <= pass sum; go to ACC; no result.
  - ACC, accept with sew=10 & count_0=1: res_data[63:0] = accumulator + pass sum (mod 2^64); [127:64]=0; res_valid next cycle; go to IDLE.
- Violations (err pulses the cycle after the offending accept):
  - IDLE with sew=10 & count_0=1: set dropped, no result.
  - ACC with sew=10 & count_0=0: old accumulator discarded, new first pass loaded, stay in ACC.
  - ACC with sew!=10: accumulator discarded, go to IDLE, new set processed normally.
  - sew=11: set dropped, no result.
- pp_valid=0 in ACC: FSM waits indefinitely.
- res_sew is registered alongside res_data.
- Reset mid-operation: discards the accumulator and any pending result immediately.

Test Plan:
- SEW=00: all lanes 0x3AB4 (0x44*0xDD), res_ready=1 -> next cycle res_valid=1, every 16-bit lane 0x3AB4, res_sew=00, err=0.
- SEW=01: lanes 0..3 = 0x1860, 0x1178, 0x0870, 0x060C (0x1234*0x5678), lanes 4..7=0 -> res_data[31:0]=0x06260060, [63:32]=0.
- SEW=10 carry stress: all lanes 0xFE01 in pass 0 then pass 1 on consecutive cycles -> no result after pass 0; one cycle after pass 1, res_data[63:0]=0xFFFFFFFE00000001, [127:64]=0.
- Backpressure: hold res_ready=0 after a SEW=00 result -> pp_ready=0 and res_data stable for 3 cycles; raising res_ready drains, next set is accepted.
- Protocol errors: sew=10/count_0=1 from IDLE -> err pulse, no res_valid; pass0, then a sew=00 set -> err pulse, SEW=00 result still produced, FSM back in IDLE.
- Reset mid-op: assert reset asynchronously between pass 0 and pass 1 -> outputs 0 immediately; a following pass 1 gives an err pulse and no result.

Source files
------------

// File: rtl/mult_product_combiner.sv
// Combines eight 16-bit lane partial products into 8x16, 2x32 or 1x64-bit unsigned products.
// Latency 1 through a valid/ready output register; SEW=32 takes two accepted passes.
module mult_product_combiner #(
    parameter int LANES = 8,
    parameter int PPW   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pp_valid,
    output logic                   pp_ready,
    input  logic [LANES*PPW-1:0]   pp_in,
    input  logic [1:0]             sew,
    input  logic                   count_0,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [LANES*PPW-1:0]   res_data,
    output logic [1:0]             res_sew,
    output logic                   err
);

    localparam int W = LANES * PPW;

    typedef enum logic {IDLE, ACC} state_t;

    state_t         fsm_q, fsm_d;
    logic [63:0]    acc_q, acc_d;
    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic [1:0]     res_sew_q, res_sew_d;
    logic           err_q, err_d;

    logic           accept;
    logic [63:0]    pass_sum;
    logic [31:0]    p16 [2];
    logic           load;
    logic [W-1:0]   load_data;
    logic [5:0]     sh;

    assign pp_ready = ~res_valid_q | res_ready;
    assign accept   = pp_valid & pp_ready;

    // Lane k = 4*i + j sits at byte weight i + j (+2 on the second SEW=32 pass).
    always_comb begin
        pass_sum = '0;
        sh       = '0;
        for (int k = 0; k < LANES; k++) begin
            sh       = 6'(8 * ((k / 4) + (k % 4))) + (count_0 ? 6'd16 : 6'd0);
            pass_sum = pass_sum + (64'(pp_in[PPW*k +: PPW]) << sh);
        end
    end

    always_comb begin
        for (int e = 0; e < 2; e++) begin
            p16[e] = 32'(pp_in[PPW*(4*e)   +: PPW])
                   + (32'(pp_in[PPW*(4*e+1) +: PPW]) << 8)
                   + (32'(pp_in[PPW*(4*e+2) +: PPW]) << 8)
                   + (32'(pp_in[PPW*(4*e+3) +: PPW]) << 16);
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        acc_d       = acc_q;
        res_valid_d = res_valid_q & ~res_ready;
        res_data_d  = res_data_q;
        res_sew_d   = res_sew_q;
        err_d       = 1'b0;
        load        = 1'b0;
        load_data   = '0;

        if (accept) begin
            case (sew)
                2'b00, 2'b01: begin
                    load      = 1'b1;
                    load_data = (sew == 2'b00) ? pp_in : {64'd0, p16[1], p16[0]};
                    // A non-SEW=32 set arriving mid-pair abandons the half-built product.
                    if (fsm_q == ACC) begin
                        err_d = 1'b1;
                        acc_d = '0;
                        fsm_d = IDLE;
                    end
                end
                2'b10: begin
                    if (!count_0) begin
                        err_d = (fsm_q == ACC);
                        acc_d = pass_sum;
                        fsm_d = ACC;
                    end else if (fsm_q == ACC) begin
                        load      = 1'b1;
                        load_data = {64'd0, acc_q + pass_sum};
                        acc_d     = '0;
                        fsm_d     = IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    err_d = 1'b1;
                    acc_d = '0;
                    fsm_d = IDLE;
                end
            endcase
        end

        if (load) begin
            res_valid_d = 1'b1;
            res_data_d  = load_data;
            res_sew_d   = sew;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= IDLE;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sew_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            acc_q       <= acc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_sew_q   <= res_sew_d;
            err_q       <= err_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_sew   = res_sew_q;
    assign err       = err_q;

endmodule
